// File: rtl/block_mover_pkg.sv
// Shared types and screen geometry for the falling-block position generator.
// Screen size is shared with the sprite renderer and the video generator.
package block_pkg;

  typedef enum logic [1:0] {
    FALLING,
    LANDED,
    SPAWN
  } block_state_t;

  localparam int SCREEN_W = 1280;
  localparam int SCREEN_H = 720;

  function automatic logic [11:0] min12(
    input logic [11:0] a,
    input logic [11:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/block_mover_if.sv
// Frame strobe, user requests and block position outputs bundled together.
// The slave side is the mover; the master side is its driver and observer.
interface block_mover_if;

  logic        nf_in;
  logic        left_in;
  logic        right_in;
  logic        drop_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        is_fixed_out;
  logic        landed_out;

  modport master (
    output nf_in,
    output left_in,
    output right_in,
    output drop_in,
    input  x_out,
    input  y_out,
    input  is_fixed_out,
    input  landed_out
  );

  modport slave (
    input  nf_in,
    input  left_in,
    input  right_in,
    input  drop_in,
    output x_out,
    output y_out,
    output is_fixed_out,
    output landed_out
  );

endinterface

// File: rtl/block_mover_frame_timer.sv
// Modulo-PERIOD counter of frame ticks with terminal-count flag.
// tc_out reflects the current count, so callers can act on the same tick.
module frame_timer #(
  parameter int PERIOD = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clr_in,
  input  logic tick_in,
  output logic tc_out
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_in) begin
      cnt_d = '0;
    end else if (tick_in) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_out = (cnt_q == LAST);

endmodule

// File: rtl/block_mover.sv
// Per-frame position generator for a falling block: move, fall, land, respawn.
// Everything updates only on the frame strobe so the sprite never tears.
module block_mover
  import block_pkg::*;
#(
  parameter int WIDTH          = 256,
  parameter int HEIGHT         = 256,
  parameter int SCREEN_W       = block_pkg::SCREEN_W,
  parameter int SCREEN_H       = block_pkg::SCREEN_H,
  parameter int SPAWN_X        = 512,
  parameter int SPAWN_Y        = 0,
  parameter int MOVE_STEP      = 8,
  parameter int FALL_STEP      = 4,
  parameter int FALL_PERIOD    = 2,
  parameter int RESPAWN_FRAMES = 60
) (
  input logic          clk_in,
  input logic          rst_in,
  block_mover_if.slave bus
);

  localparam logic [11:0] X_MAX   = 12'(SCREEN_W - WIDTH);
  localparam logic [11:0] FLOOR_Y = 12'(SCREEN_H - HEIGHT);
  localparam logic [11:0] MSTEP   = 12'(MOVE_STEP);
  localparam logic [11:0] FSTEP   = 12'(FALL_STEP);
  localparam logic [11:0] DSTEP   = 12'(4 * FALL_STEP);
  localparam logic [10:0] X_SPAWN = 11'(SPAWN_X);
  localparam logic [9:0]  Y_SPAWN = 10'(SPAWN_Y);

  block_state_t state_q, state_d;
  logic [10:0]  x_q, x_d;
  logic [9:0]   y_q, y_d;
  logic         fixed_q, fixed_d;
  logic         landed_q, landed_d;

  logic        fall_tick, fall_clr, fall_tc;
  logic        hold_tick, hold_clr, hold_tc;
  logic [11:0] x_ext, y_ext, x_nxt, y_nxt, step;

  frame_timer #(.PERIOD(FALL_PERIOD)) u_fall (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clr_in  (fall_clr),
    .tick_in (fall_tick),
    .tc_out  (fall_tc)
  );

  frame_timer #(.PERIOD(RESPAWN_FRAMES)) u_hold (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clr_in  (hold_clr),
    .tick_in (hold_tick),
    .tc_out  (hold_tc)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    fixed_d   = fixed_q;
    landed_d  = 1'b0;
    fall_tick = 1'b0;
    fall_clr  = 1'b0;
    hold_tick = 1'b0;
    hold_clr  = 1'b0;
    x_ext     = {1'b0, x_q};
    y_ext     = {2'b00, y_q};
    x_nxt     = x_ext;
    y_nxt     = y_ext;
    step      = '0;
    unique case (state_q)
      FALLING: begin
        if (bus.nf_in) begin
          if (bus.left_in && !bus.right_in) begin
            x_nxt = (x_ext < MSTEP) ? '0 : x_ext - MSTEP;
          end else if (bus.right_in && !bus.left_in) begin
            x_nxt = min12(x_ext + MSTEP, X_MAX);
          end
          if (bus.drop_in) begin
            fall_clr = 1'b1;
            step     = DSTEP;
          end else begin
            fall_tick = 1'b1;
            step      = fall_tc ? FSTEP : '0;
          end
          y_nxt = min12(y_ext + step, FLOOR_Y);
          x_d   = x_nxt[10:0];
          y_d   = y_nxt[9:0];
          if (y_nxt == FLOOR_Y) begin
            state_d  = LANDED;
            fixed_d  = 1'b1;
            landed_d = 1'b1;
            hold_clr = 1'b1;
          end
        end
      end
      LANDED: begin
        if (bus.nf_in) begin
          hold_tick = 1'b1;
          if (hold_tc) begin
            state_d = SPAWN;
          end
        end
      end
      SPAWN: begin
        x_d      = X_SPAWN;
        y_d      = Y_SPAWN;
        fixed_d  = 1'b0;
        fall_clr = 1'b1;
        state_d  = FALLING;
      end
      default: begin
        state_d = FALLING;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= FALLING;
      x_q      <= X_SPAWN;
      y_q      <= Y_SPAWN;
      fixed_q  <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      fixed_q  <= fixed_d;
      landed_q <= landed_d;
    end
  end

  assign bus.x_out        = x_q;
  assign bus.y_out        = y_q;
  assign bus.is_fixed_out = fixed_q;
  assign bus.landed_out   = landed_q;

endmodule

// File: tb/tb_block_mover.sv
// Randomized bench for block_mover against a frame-level behavioural model.
// Observed values are packed as {x, y, is_fixed, landed}.
module tb_block_mover;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  block_mover_if bus ();

  block_mover dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  // Behavioural model: position, landed flag, frames since last
  // gravity step and frames spent on the floor.
  int mx, my, mgrav, mhold;
  bit mfix;

  function automatic logic [22:0] pack(int x, int y, bit f, bit l);
    return {11'(x), 10'(y), f, l};
  endfunction

  function automatic logic [22:0] obs();
    return {bus.x_out, bus.y_out, bus.is_fixed_out, bus.landed_out};
  endfunction

  task automatic model_reset();
    mx = 512; my = 0; mfix = 0; mgrav = 0; mhold = 0;
  endtask

  task automatic model_frame(
    input bit l, input bit r, input bit d,
    output bit land_ev, output bit spawn_ev
  );
    int st;
    land_ev = 0;
    spawn_ev = 0;
    if (!mfix) begin
      if (l && !r) mx = (mx < 8) ? 0 : mx - 8;
      else if (r && !l) mx = (mx + 8 > 1024) ? 1024 : mx + 8;
      st = 0;
      if (d) begin
        st = 16;
        mgrav = 0;
      end else begin
        mgrav++;
        if (mgrav == 2) begin
          st = 4;
          mgrav = 0;
        end
      end
      my = (my + st > 464) ? 464 : my + st;
      if (my == 464) begin
        mfix = 1;
        land_ev = 1;
        mhold = 0;
      end
    end else begin
      mhold++;
      if (mhold == 60) spawn_ev = 1;
    end
  endtask

  // One nf pulse with the given requests, then a random idle gap.
  // o1/e1: the cycle right after the strobe; o2/e2: end of the gap.
  task automatic do_frame(
    input bit l, input bit r, input bit d,
    output logic [22:0] o1, output logic [22:0] e1,
    output logic [22:0] o2, output logic [22:0] e2
  );
    bit land_ev, spawn_ev;
    int gap;
    @(negedge clk);
    bus.left_in = l; bus.right_in = r; bus.drop_in = d;
    bus.nf_in = 1'b1;
    @(negedge clk);
    bus.nf_in = 1'b0;
    bus.left_in = 1'($urandom);
    bus.right_in = 1'($urandom);
    bus.drop_in = 1'($urandom);
    o1 = obs();
    model_frame(l, r, d, land_ev, spawn_ev);
    e1 = pack(mx, my, mfix, land_ev);
    if (spawn_ev) model_reset();
    e2 = pack(mx, my, mfix, 1'b0);
    gap = $urandom_range(1, 3);
    repeat (gap) @(negedge clk);
    o2 = obs();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.nf_in = 1'b1;
    bus.drop_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.nf_in = 1'b0;
    bus.drop_in = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (obs() !== pack(512, 0, 0, 0)) begin
      bad++;
      $display("FAIL reset got %h want %h", obs(), pack(512, 0, 0, 0));
    end
  endtask

  task automatic test_gravity();
    logic [22:0] o1, e1, o2, e2;
    for (int i = 0; i < 10; i++) begin
      do_frame(0, 0, 0, o1, e1, o2, e2);
      total++;
      if (o1 !== e1) begin
        bad++;
        $display("FAIL gravity f%0d got %h want %h", i, o1, e1);
      end
      total++;
      if (o2 !== e2) begin
        bad++;
        $display("FAIL gravity_hold f%0d got %h want %h", i, o2, e2);
      end
    end
    total++;
    if (obs() !== pack(512, 20, 0, 0)) begin
      bad++;
      $display("FAIL gravity_y20 got %h want %h", obs(), pack(512, 20, 0, 0));
    end
  endtask

  task automatic test_left();
    logic [22:0] o1, e1, o2, e2;
    for (int i = 0; i < 75; i++) begin
      if (i < 70) do_frame(1, 0, 0, o1, e1, o2, e2);
      else do_frame(1, 1, 0, o1, e1, o2, e2);
      total++;
      if (o1 !== e1 || o2 !== e2) begin
        bad++;
        $display("FAIL left f%0d got %h/%h want %h/%h", i, o1, o2, e1, e2);
      end
    end
    total++;
    if (bus.x_out !== 11'd0) begin
      bad++;
      $display("FAIL left_clamp got %0d want 0", bus.x_out);
    end
  endtask

  task automatic test_right();
    logic [22:0] o1, e1, o2, e2;
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      do_frame(0, 1, 0, o1, e1, o2, e2);
      total++;
      if (o1 !== e1 || o2 !== e2 || o1[22:12] > 11'd1024) begin
        bad++;
        $display("FAIL right f%0d got %h/%h want %h/%h", i, o1, o2, e1, e2);
      end
    end
    total++;
    if (bus.x_out !== 11'd1024) begin
      bad++;
      $display("FAIL right_clamp got %0d want 1024", bus.x_out);
    end
  endtask

  task automatic test_drop_land_respawn();
    logic [22:0] o1, e1, o2, e2;
    apply_reset();
    for (int i = 1; i <= 29; i++) begin
      do_frame(0, 0, 1, o1, e1, o2, e2);
      total++;
      if (o1 !== pack(512, 16 * i, i == 29, i == 29) || o2 !== e2) begin
        bad++;
        $display("FAIL drop f%0d got %h/%h want %h/%h", i, o1, o2,
                 pack(512, 16 * i, i == 29, i == 29), e2);
      end
    end
    for (int i = 1; i <= 60; i++) begin
      do_frame(1'($urandom), 1'($urandom), 1'($urandom), o1, e1, o2, e2);
      total++;
      if (o1 !== pack(512, 464, 1, 0)) begin
        bad++;
        $display("FAIL landed_hold f%0d got %h want %h", i, o1,
                 pack(512, 464, 1, 0));
      end
      total++;
      if (o2 !== e2) begin
        bad++;
        $display("FAIL respawn f%0d got %h want %h", i, o2, e2);
      end
    end
    total++;
    if (obs() !== pack(512, 0, 0, 0)) begin
      bad++;
      $display("FAIL respawn_pos got %h want %h", obs(), pack(512, 0, 0, 0));
    end
    for (int i = 0; i < 4; i++) begin
      do_frame(0, 0, 0, o1, e1, o2, e2);
      total++;
      if (o2 !== e2) begin
        bad++;
        $display("FAIL resume f%0d got %h want %h", i, o2, e2);
      end
    end
  endtask

  task automatic test_rst_mid_fall();
    logic [22:0] o1, e1, o2, e2;
    apply_reset();
    for (int i = 0; i < 28; i++) do_frame(0, 1, 1, o1, e1, o2, e2);
    total++;
    if (o2 !== e2) begin
      bad++;
      $display("FAIL pre_rst got %h want %h", o2, e2);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.nf_in = 1'b1;
    bus.drop_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.nf_in = 1'b0;
    bus.drop_in = 1'b0;
    model_reset();
    total++;
    if (obs() !== pack(512, 0, 0, 0)) begin
      bad++;
      $display("FAIL rst_nf got %h want %h", obs(), pack(512, 0, 0, 0));
    end
    @(negedge clk);
    total++;
    if (obs() !== pack(512, 0, 0, 0)) begin
      bad++;
      $display("FAIL rst_no_pulse got %h want %h", obs(), pack(512, 0, 0, 0));
    end
  endtask

  task automatic test_random();
    logic [22:0] o1, e1, o2, e2;
    bit l, r, d;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      l = 1'($urandom);
      r = 1'($urandom);
      d = ($urandom_range(0, 3) == 0);
      do_frame(l, r, d, o1, e1, o2, e2);
      total++;
      if (o1 !== e1) begin
        bad++;
        $display("FAIL random f%0d got %h want %h", i, o1, e1);
      end
      total++;
      if (o2 !== e2) begin
        bad++;
        $display("FAIL random_gap f%0d got %h want %h", i, o2, e2);
      end
    end
  endtask

  initial begin
    bus.nf_in = 1'b0;
    bus.left_in = 1'b0;
    bus.right_in = 1'b0;
    bus.drop_in = 1'b0;
    model_reset();
    test_reset();
    test_gravity();
    test_left();
    test_right();
    test_drop_land_respawn();
    test_rst_mid_fall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
